// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit.
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ARITH_ADD = 2'b00,
    ARITH_SUB = 2'b01,
    ARITH_MUL = 2'b10,
    ARITH_DIV = 2'b11
  } arith_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_FIN  = 2'b10
  } arith_state_e;

endpackage

// File: rtl/arith_unit_seq_if.sv
// Operand/result bus between the ALU top-level and the arithmetic unit.
interface arith_unit_seq_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [3:0]         ALU_FUN;
  logic               arth_enable;
  logic               busy;
  logic               arth_flag;
  logic               carry_out;
  logic               overflow;
  logic               div_zero;
  logic [2*WIDTH-1:0] Arthmtic_out;
  logic [WIDTH-1:0]   remainder;

  modport master (
    output A, B, ALU_FUN, arth_enable,
    input  busy, arth_flag, carry_out, overflow, div_zero, Arthmtic_out, remainder
  );

  modport slave (
    input  A, B, ALU_FUN, arth_enable,
    output busy, arth_flag, carry_out, overflow, div_zero, Arthmtic_out, remainder
  );

endinterface

// File: rtl/seq_divider_u.sv
// Unsigned restoring divider, one quotient bit per clock.
// done_o is high during the final iteration; quotient/remainder are valid after that edge.
module seq_divider_u #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;
  logic [WIDTH:0]   rem_shift, trial;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
  end

  assign done_o      = run_q && (cnt_q == CntW'(1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Load on start, then shift in one quotient bit per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= CntW'(WIDTH);
      run_q <= 1'b1;
    end else if (run_q) begin
      // A set top bit of trial means the subtraction borrowed: restore.
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/arith_unit_seq.sv
// Signed add/sub/mul (one cycle) and iterative signed divide with remainder,
// busy/done handshake, overflow and divide-by-zero flags.
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic             clock,
  input logic             rest,
  arith_unit_seq_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned W2  = 2 * WIDTH;

  arith_state_e     state_q;
  arith_op_e        op_q;
  arith_op_e        op_in;
  logic [WIDTH-1:0] a_q, b_q;
  logic             pend_q;
  logic             busy_q, flag_q, carry_q, ovf_q, dz_q;
  logic [W2-1:0]    out_q;
  logic [WIDTH-1:0] rem_q;

  logic             accept, div_start;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    sc_out;
  logic [WIDTH-1:0] sc_rem;
  logic             sc_c, sc_v, sc_z;
  logic [W2-1:0]    q_ext, div_out;
  logic [WIDTH-1:0] rem_fin;
  logic             div_ovf;

  // Upper function bits select other ALU units and are not decoded here.
  logic unused_fun;
  assign unused_fun = ^bus.ALU_FUN[3:2];

  assign op_in     = arith_op_e'(bus.ALU_FUN[1:0]);
  assign accept    = (state_q == ST_IDLE) && bus.arth_enable;
  assign div_start = accept && (op_in == ARITH_DIV) && (bus.B != '0);

  // Unsigned WIDTH-bit negation covers |MIN| = 2^(WIDTH-1) exactly.
  assign a_mag_in = bus.A[MSB] ? -bus.A : bus.A;
  assign b_mag_in = bus.B[MSB] ? -bus.B : bus.B;

  seq_divider_u #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk_i      (clock),
    .rst_ni     (rest),
    .start_i    (div_start),
    .dividend_i (a_mag_in),
    .divisor_i  (b_mag_in),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // Single-cycle results from the operands captured at accept.
  always_comb begin
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    dif_ext = {1'b0, a_q} - {1'b0, b_q};
    prod    = $signed({{WIDTH{a_q[MSB]}}, a_q}) * $signed({{WIDTH{b_q[MSB]}}, b_q});
    sc_out  = '0;
    sc_rem  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_z    = 1'b0;
    unique case (op_q)
      ARITH_ADD: begin
        sc_out = {{WIDTH{sum_ext[MSB]}}, sum_ext[MSB:0]};
        sc_c   = sum_ext[WIDTH];
        sc_v   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
      end
      ARITH_SUB: begin
        sc_out = {{WIDTH{dif_ext[MSB]}}, dif_ext[MSB:0]};
        sc_c   = dif_ext[WIDTH];
        sc_v   = (a_q[MSB] != b_q[MSB]) && (dif_ext[MSB] != a_q[MSB]);
      end
      ARITH_MUL: sc_out = prod;
      // Only a zero divisor takes the single-cycle path for divide.
      ARITH_DIV: begin
        sc_rem = a_q;
        sc_z   = 1'b1;
      end
      default: ;
    endcase
  end

  // Sign correction of the unsigned divider result.
  always_comb begin
    q_ext   = {{WIDTH{1'b0}}, div_quo};
    div_out = (a_q[MSB] ^ b_q[MSB]) ? -q_ext : q_ext;
    rem_fin = a_q[MSB] ? -div_rem : div_rem;
    div_ovf = (a_q == {1'b1, {MSB{1'b0}}}) && (&b_q);
  end

  // Control FSM with operand capture and registered outputs.
  always_ff @(posedge clock or negedge rest) begin
    if (!rest) begin
      state_q <= ST_IDLE;
      op_q    <= ARITH_ADD;
      a_q     <= '0;
      b_q     <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= '0;
      rem_q   <= '0;
    end else begin
      flag_q <= 1'b0;
      pend_q <= accept && !div_start;
      if (accept) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= op_in;
      end
      if (pend_q) begin
        out_q   <= sc_out;
        rem_q   <= sc_rem;
        carry_q <= sc_c;
        ovf_q   <= sc_v;
        dz_q    <= sc_z;
        flag_q  <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (div_start) begin
            state_q <= ST_DIV;
            busy_q  <= 1'b1;
          end
        end
        ST_DIV: begin
          if (div_done) state_q <= ST_FIN;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          out_q   <= div_out;
          rem_q   <= rem_fin;
          carry_q <= 1'b0;
          ovf_q   <= div_ovf;
          dz_q    <= 1'b0;
          flag_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.arth_flag    = flag_q;
  assign bus.carry_out    = carry_q;
  assign bus.overflow     = ovf_q;
  assign bus.div_zero     = dz_q;
  assign bus.Arthmtic_out = out_q;
  assign bus.remainder    = rem_q;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Bench for arith_unit_seq at WIDTH=16: directed table, hand sequences, random vs model.
module tb_arith_unit_seq;

  localparam int unsigned W = 16;

  logic clock = 1'b0;
  logic rest;
  always #5 clock = ~clock;

  arith_unit_seq_if #(.WIDTH(W)) bus ();

  arith_unit_seq #(
    .WIDTH(W)
  ) dut (
    .clock(clock),
    .rest (rest),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] out;
    logic [15:0] rem;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] out, input logic [15:0] rem,
                         input logic c, input logic v, input logic z);
    vec_t t;
    t.name = name; t.op = op; t.a = a; t.b = b;
    t.out = out; t.rem = rem; t.c = c; t.v = v; t.z = z;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on the operands.
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] o, output logic [15:0] r,
                                output logic c, output logic v, output logic z);
    longint as, bs, au, bu, res, rr;
    as = longint'($signed(a));
    bs = longint'($signed(b));
    au = longint'(a);
    bu = longint'(b);
    o = '0; r = '0; c = 1'b0; v = 1'b0; z = 1'b0;
    case (op)
      2'd0: begin
        res = as + bs;
        v = (res > 32767) || (res < -32768);
        c = (au + bu) > 65535;
        o = {{16{res[15]}}, res[15:0]};
      end
      2'd1: begin
        res = as - bs;
        v = (res > 32767) || (res < -32768);
        c = au < bu;
        o = {{16{res[15]}}, res[15:0]};
      end
      2'd2: begin
        res = as * bs;
        o = res[31:0];
      end
      default: begin
        if (b == 16'h0) begin
          z = 1'b1;
          r = a;
        end else begin
          res = as / bs;
          rr  = as % bs;
          v = res > 32767;
          o = res[31:0];
          r = rr[15:0];
        end
      end
    endcase
  endfunction

  // Issue one op, wait (bounded) for the flag, then compare result, latency and busy length.
  task automatic apply_and_check(input string name, input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [31:0] e_out,
                                 input logic [15:0] e_rem, input logic e_c, input logic e_v,
                                 input logic e_z, input int poke);
    int exp_lat, lat, busy_cnt;
    logic got;
    logic [1:0] hi;
    exp_lat = (op == 2'd3 && b != 16'h0) ? W + 1 : 1;
    hi = 2'($urandom_range(3, 0));
    @(negedge clock);
    bus.A = a; bus.B = b; bus.ALU_FUN = {hi, op}; bus.arth_enable = 1'b1;
    @(posedge clock); #1;
    bus.arth_enable = 1'b0;
    bus.A = 16'($urandom); bus.B = 16'($urandom); bus.ALU_FUN = 4'($urandom);
    got = 1'b0; lat = 0; busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy) busy_cnt++;
      if (c == poke) begin
        bus.arth_enable = 1'b1;
        bus.ALU_FUN = 4'h0;
      end
      @(posedge clock); #1;
      bus.arth_enable = 1'b0;
      if (bus.arth_flag) begin
        lat = c;
        got = 1'b1;
        break;
      end
    end
    check({name, " flag_seen"}, 64'(got), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy_cycles"}, 64'(busy_cnt), (exp_lat == 1) ? 64'd0 : 64'(W + 1));
    check({name, " out"}, 64'(bus.Arthmtic_out), 64'(e_out));
    check({name, " rem"}, 64'(bus.remainder), 64'(e_rem));
    check({name, " flags_cvz"}, 64'({bus.carry_out, bus.overflow, bus.div_zero}),
          64'({e_c, e_v, e_z}));
    @(posedge clock); #1;
    check({name, " flag_pulse"}, 64'(bus.arth_flag), 64'd0);
    check({name, " out_hold"}, 64'(bus.Arthmtic_out), 64'(e_out));
  endtask

  initial begin
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [31:0] m_out;
    logic [15:0] m_rem;
    logic        m_c, m_v, m_z;
    logic        seen;

    rest = 1'b0;
    bus.A = '0; bus.B = '0; bus.ALU_FUN = '0; bus.arth_enable = 1'b0;

    add_vec("add_ovf",     2'd0, 16'h7FFF, 16'h0001, 32'hFFFF8000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add_vec("sub_borrow",  2'd1, 16'h0003, 16'h0005, 32'hFFFFFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec("mul_neg",     2'd2, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 16'h0000, 1'b0, 1'b0, 1'b0);
    add_vec("div_m7_2",    2'd3, 16'hFFF9, 16'h0002, 32'hFFFFFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    add_vec("div_by_zero", 2'd3, 16'h0005, 16'h0000, 32'h00000000, 16'h0005, 1'b0, 1'b0, 1'b1);
    add_vec("div_min_m1",  2'd3, 16'h8000, 16'hFFFF, 32'h00008000, 16'h0000, 1'b0, 1'b1, 1'b0);
    add_vec("div_100_7",   2'd3, 16'h0064, 16'h0007, 32'h0000000E, 16'h0002, 1'b0, 1'b0, 1'b0);
    add_vec("add_carry",   2'd0, 16'hFFFF, 16'h0001, 32'h00000000, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec("sub_ovf",     2'd1, 16'h8000, 16'h0001, 32'h00007FFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    add_vec("mul_min_min", 2'd2, 16'h8000, 16'h8000, 32'h40000000, 16'h0000, 1'b0, 1'b0, 1'b0);
    add_vec("div_7_m2",    2'd3, 16'h0007, 16'hFFFE, 32'hFFFFFFFD, 16'h0001, 1'b0, 1'b0, 1'b0);
    add_vec("div_min_1",   2'd3, 16'h8000, 16'h0001, 32'hFFFF8000, 16'h0000, 1'b0, 1'b0, 1'b0);
    add_vec("add_min_min", 2'd0, 16'h8000, 16'h8000, 32'h00000000, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset out", 64'(bus.Arthmtic_out), 64'd0);
    check("reset rem", 64'(bus.remainder), 64'd0);
    check("reset ctl", 64'({bus.busy, bus.arth_flag, bus.carry_out, bus.overflow,
                            bus.div_zero}), 64'd0);
    @(negedge clock);
    rest = 1'b1;

    // Directed table; divides get a stray enable pulse at cycle 5.
    foreach (vecs[i]) begin
      apply_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out,
                      vecs[i].rem, vecs[i].c, vecs[i].v, vecs[i].z,
                      (vecs[i].op == 2'd3 && vecs[i].b != 16'h0) ? 5 : 0);
    end

    // Back-to-back sub then mul.
    @(negedge clock);
    bus.A = 16'h0003; bus.B = 16'h0005; bus.ALU_FUN = 4'h1; bus.arth_enable = 1'b1;
    @(posedge clock); #1;
    bus.A = 16'hFFFD; bus.B = 16'h0007; bus.ALU_FUN = 4'h2;
    @(posedge clock); #1;
    bus.arth_enable = 1'b0;
    check("b2b sub flag", 64'(bus.arth_flag), 64'd1);
    check("b2b sub out", 64'(bus.Arthmtic_out), 64'hFFFFFFFE);
    check("b2b sub carry", 64'(bus.carry_out), 64'd1);
    @(posedge clock); #1;
    check("b2b mul flag", 64'(bus.arth_flag), 64'd1);
    check("b2b mul out", 64'(bus.Arthmtic_out), 64'hFFFFFFEB);
    check("b2b mul carry", 64'(bus.carry_out), 64'd0);
    @(posedge clock); #1;
    check("b2b flag low", 64'(bus.arth_flag), 64'd0);
    check("b2b out hold", 64'(bus.Arthmtic_out), 64'hFFFFFFEB);

    // Reset in the middle of a divide.
    @(negedge clock);
    bus.A = 16'h0064; bus.B = 16'h0007; bus.ALU_FUN = 4'h3; bus.arth_enable = 1'b1;
    @(posedge clock); #1;
    bus.arth_enable = 1'b0;
    check("midrst busy before", 64'(bus.busy), 64'd1);
    repeat (7) @(posedge clock);
    #1;
    rest = 1'b0;
    #1;
    check("midrst out", 64'(bus.Arthmtic_out), 64'd0);
    check("midrst rem", 64'(bus.remainder), 64'd0);
    check("midrst ctl", 64'({bus.busy, bus.arth_flag, bus.carry_out, bus.overflow,
                             bus.div_zero}), 64'd0);
    @(negedge clock);
    rest = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clock); #1;
      if (bus.arth_flag || bus.busy) seen = 1'b1;
    end
    check("midrst no flag/busy", 64'(seen), 64'd0);
    apply_and_check("post_rst_add", 2'd0, 16'h0001, 16'h0002, 32'h00000003, 16'h0000,
                    1'b0, 1'b0, 1'b0, 0);

    // Random operations against the model.
    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(3, 0));
      a  = 16'($urandom);
      b  = 16'($urandom);
      case ($urandom_range(9, 0))
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: a = 16'h8000;
        default: ;
      endcase
      model(op, a, b, m_out, m_rem, m_c, m_v, m_z);
      apply_and_check($sformatf("rnd%0d op%0d %h_%h", n, op, a, b), op, a, b, m_out, m_rem,
                      m_c, m_v, m_z,
                      (op == 2'd3 && b != 16'h0) ? int'($urandom_range(16, 1)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
